// File: rtl/cpc_bank_wr_sync.sv
// Synchronous front-end for the CPC RAM expansion bank register: synchronises the Z80 strobes,
// filters glitches and commits D5..D0 of a qualified gate-array write. Optional macro: FULL_DECODE_EN.
module cpc_bank_wr_sync #(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned FILTER_CYCLES = 3,
   parameter int unsigned GLITCH_W      = 8
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                IOREQ_B,
   input  logic                WR_B,
   input  logic                M1_B,
   input  logic [7:0]          A_HI,
   input  logic [7:0]          D,
   output logic                bank_wr,
   output logic [5:0]          bank_reg,
   output logic                busy,
   output logic [GLITCH_W-1:0] glitch_cnt
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      QUAL   = 2'd1,
      ACTIVE = 2'd2
   } state_t;

   localparam logic [3:0] FILT_MAX  = 4'(FILTER_CYCLES);
   localparam logic [3:0] FILT_LAST = 4'(FILTER_CYCLES - 1);

   // strobe chain bit order: {IOREQ_B, WR_B, M1_B}
   logic [SYNC_STAGES-1:0][2:0] strb_sync;
   logic [SYNC_STAGES-1:0][7:0] a_sync;
   logic [SYNC_STAGES-1:0][7:0] d_sync;

   logic       ioreq_s;
   logic       wr_s;
   logic       m1_s;
   logic [7:0] a_s;
   logic [7:0] d_s;
   logic       strobe;
   logic       match;
   logic       addr_ok;

   state_t     state;
   state_t     state_nxt;
   logic [3:0] filt_cnt;
   logic [3:0] filt_nxt;
   logic [5:0] data_reg;
   logic       capture;
   logic       commit;
   logic       glitch_inc;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         strb_sync <= '1;
         a_sync    <= '0;
         d_sync    <= '0;
      end else begin
         strb_sync <= {strb_sync[SYNC_STAGES-2:0], {IOREQ_B, WR_B, M1_B}};
         a_sync    <= {a_sync[SYNC_STAGES-2:0], A_HI};
         d_sync    <= {d_sync[SYNC_STAGES-2:0], D};
      end
   end

   assign ioreq_s = strb_sync[SYNC_STAGES-1][2];
   assign wr_s    = strb_sync[SYNC_STAGES-1][1];
   assign m1_s    = strb_sync[SYNC_STAGES-1][0];
   assign a_s     = a_sync[SYNC_STAGES-1];
   assign d_s     = d_sync[SYNC_STAGES-1];

   // M1 low with IOREQ low is an interrupt acknowledge, never a port write
   assign strobe = ~ioreq_s & ~wr_s & m1_s;

`ifdef FULL_DECODE_EN
   assign addr_ok = ~a_s[7] & (a_s[6:0] == 7'h7F);
`else
   logic unused_addr;
   assign unused_addr = ^a_s[6:0];
   assign addr_ok     = ~a_s[7];
`endif

   assign match   = addr_ok & d_s[7] & d_s[6];
   assign capture = strobe & match;

   always_comb begin
      state_nxt  = state;
      filt_nxt   = filt_cnt;
      commit     = 1'b0;
      glitch_inc = 1'b0;
      case (state)
         IDLE: begin
            if (strobe && match) begin
               state_nxt = QUAL;
               filt_nxt  = 4'd1;
            end
         end
         QUAL: begin
            if (strobe && match) begin
               if (filt_cnt >= FILT_LAST) begin
                  state_nxt = ACTIVE;
               end else begin
                  filt_nxt = filt_cnt + 4'd1;
               end
            end else if (filt_cnt >= FILT_MAX) begin
               // already qualified on entry (single-sample filter): treat release as a real write
               state_nxt = IDLE;
               commit    = ~strobe;
               glitch_inc = strobe;
            end else begin
               state_nxt  = IDLE;
               glitch_inc = 1'b1;
            end
         end
         ACTIVE: begin
            if (!strobe) begin
               state_nxt = IDLE;
               commit    = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= IDLE;
         filt_cnt   <= '0;
         data_reg   <= '0;
         bank_reg   <= '0;
         bank_wr    <= 1'b0;
         glitch_cnt <= '0;
      end else begin
         state    <= state_nxt;
         filt_cnt <= filt_nxt;
         bank_wr  <= commit;
         if (capture) begin
            data_reg <= d_s[5:0];
         end
         if (commit) begin
            bank_reg <= data_reg;
         end
         if (glitch_inc && (glitch_cnt != '1)) begin
            glitch_cnt <= glitch_cnt + 1'b1;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule
